// File: rtl/rmt_ingress_arbiter.sv
// Packet-granular round-robin arbiter merging the config (s0) and data (s1)
// AXI-Stream sources into one registered stream, with per-source packet counters.
module rmt_ingress_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_CNT_WIDTH        = 16
) (
    input  logic                                 clk,
    input  logic                                 aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s0_axis_tuser,
    input  logic                                 s0_axis_tvalid,
    input  logic                                 s0_axis_tlast,
    output logic                                 s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s1_axis_tuser,
    input  logic                                 s1_axis_tvalid,
    input  logic                                 s1_axis_tlast,
    output logic                                 s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,

    output logic [PKT_CNT_WIDTH-1:0]             pkt_cnt0,
    output logic [PKT_CNT_WIDTH-1:0]             pkt_cnt1,
    output logic [1:0]                           grant_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       out_free;
    logic       acc0;
    logic       acc1;

    // Readies depend only on state and downstream backpressure, never on tvalid.
    assign out_free       = !m_axis_tvalid || m_axis_tready;
    assign s0_axis_tready = (state == GRANT0) && out_free;
    assign s1_axis_tready = (state == GRANT1) && out_free;
    assign acc0           = s0_axis_tvalid && s0_axis_tready;
    assign acc1           = s1_axis_tvalid && s1_axis_tready;
    assign grant_state    = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid)
                    state_nxt = last_grant ? GRANT0 : GRANT1;
                else if (s0_axis_tvalid)
                    state_nxt = GRANT0;
                else if (s1_axis_tvalid)
                    state_nxt = GRANT1;
            end
            GRANT0: if (acc0 && s0_axis_tlast) state_nxt = IDLE;
            GRANT1: if (acc1 && s1_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            pkt_cnt0      <= '0;
            pkt_cnt1      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            state <= state_nxt;

            // Packets are counted on acceptance from the source, not on delivery.
            if (acc0 && s0_axis_tlast) begin
                last_grant <= 1'b0;
                pkt_cnt0   <= pkt_cnt0 + PKT_CNT_WIDTH'(1);
            end
            if (acc1 && s1_axis_tlast) begin
                last_grant <= 1'b1;
                pkt_cnt1   <= pkt_cnt1 + PKT_CNT_WIDTH'(1);
            end

            if (acc0) begin
                m_axis_tdata  <= s0_axis_tdata;
                m_axis_tkeep  <= s0_axis_tkeep;
                m_axis_tuser  <= s0_axis_tuser;
                m_axis_tlast  <= s0_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else if (acc1) begin
                m_axis_tdata  <= s1_axis_tdata;
                m_axis_tkeep  <= s1_axis_tkeep;
                m_axis_tuser  <= s1_axis_tuser;
                m_axis_tlast  <= s1_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Directed bench for rmt_ingress_arbiter: vector table for grant/latency
// behaviour plus sequences for alternation, stall, mid-packet reset and counter wrap.
module tb_rmt_ingress_arbiter;

    logic          clk = 1'b0;
    logic          aresetn = 1'b1;
    logic [511:0]  s0_axis_tdata = '0, s1_axis_tdata = '0;
    logic [63:0]   s0_axis_tkeep = '0, s1_axis_tkeep = '0;
    logic [127:0]  s0_axis_tuser = '0, s1_axis_tuser = '0;
    logic          s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
    logic          s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
    logic          s0_axis_tready, s1_axis_tready;
    logic [511:0]  m_axis_tdata;
    logic [63:0]   m_axis_tkeep;
    logic [127:0]  m_axis_tuser;
    logic          m_axis_tlast, m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [15:0]   pkt_cnt0, pkt_cnt1;
    logic [1:0]    grant_state;

    logic [511:0]  w2_tdata;
    logic [63:0]   w2_tkeep;
    logic [127:0]  w2_tuser;
    logic          w2_tlast, w2_tvalid, w2_s0_tready, w2_s1_tready;
    logic [1:0]    w2_cnt0, w2_cnt1, w2_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rmt_ingress_arbiter dut (
        .clk(clk), .aresetn(aresetn),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .grant_state(grant_state)
    );

    rmt_ingress_arbiter #(.PKT_CNT_WIDTH(2)) dut_w2 (
        .clk(clk), .aresetn(aresetn),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(w2_s0_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(w2_s1_tready),
        .m_axis_tdata(w2_tdata), .m_axis_tkeep(w2_tkeep), .m_axis_tuser(w2_tuser),
        .m_axis_tlast(w2_tlast), .m_axis_tvalid(w2_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_cnt0(w2_cnt0), .pkt_cnt1(w2_cnt1), .grant_state(w2_state)
    );

    typedef struct {
        bit          rst;
        bit          s0v, s0l;
        logic [15:0] s0t;
        bit          s1v, s1l;
        logic [15:0] s1t;
        bit          mrdy;
        bit          e0r, e1r;
        bit          emv, eml;
        logic [15:0] etag;
        logic [1:0]  est;
        int          ec0, ec1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit s0v, bit s0l, logic [15:0] s0t,
                                bit s1v, bit s1l, logic [15:0] s1t, bit mrdy,
                                bit e0r, bit e1r, bit emv, bit eml, logic [15:0] etag,
                                logic [1:0] est, int ec0, int ec1);
        vec_t r;
        r.rst = rst; r.s0v = s0v; r.s0l = s0l; r.s0t = s0t;
        r.s1v = s1v; r.s1l = s1l; r.s1t = s1t; r.mrdy = mrdy;
        r.e0r = e0r; r.e1r = e1r; r.emv = emv; r.eml = eml; r.etag = etag;
        r.est = est; r.ec0 = ec0; r.ec1 = ec1;
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every beat carries a 16-bit tag replicated across tdata/tkeep/tuser.
    task automatic drive_src(input int src, input bit v, input bit last, input logic [15:0] tag);
        if (src == 0) begin
            s0_axis_tvalid = v; s0_axis_tlast = last;
            s0_axis_tdata = {32{tag}}; s0_axis_tkeep = {4{tag}}; s0_axis_tuser = {8{tag}};
        end else begin
            s1_axis_tvalid = v; s1_axis_tlast = last;
            s1_axis_tdata = {32{tag}}; s1_axis_tkeep = {4{tag}}; s1_axis_tuser = {8{tag}};
        end
    endtask

    task automatic check_beat(input string name, input logic [15:0] tag, input bit last);
        check({name, "_tdata"}, m_axis_tdata, {32{tag}});
        check({name, "_tkeep"}, 512'(m_axis_tkeep), 512'({4{tag}}));
        check({name, "_tuser"}, 512'(m_axis_tuser), 512'({8{tag}}));
        check({name, "_tlast"}, 512'(m_axis_tlast), 512'(last));
    endtask

    task automatic do_reset();
        drive_src(0, 0, 0, 16'h0);
        drive_src(1, 0, 0, 16'h0);
        m_axis_tready = 1'b1;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Send one packet from src with m_axis_tready held high; checks every delivered beat.
    task automatic run_pkt(input int src, input logic [15:0] base, input int nbeats);
        int sent = 0;
        int rx = 0;
        bit rdy, mv, vv;
        for (int cyc = 0; cyc < 50 && rx < nbeats; cyc++) begin
            vv = (sent < nbeats);
            drive_src(src, vv, sent == nbeats - 1, base + 16'(sent));
            m_axis_tready = 1'b1;
            #1;
            rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
            mv  = m_axis_tvalid;
            if (mv) begin
                check_beat("pkt_beat", base + 16'(rx), rx == nbeats - 1);
                rx++;
            end
            @(posedge clk);
            #1;
            if (vv && rdy) sent++;
        end
        drive_src(src, 0, 0, 16'h0);
        check("pkt_beats_delivered", 512'(rx), 512'(nbeats));
    endtask

    initial begin
        int sent0, sent1, rx, stall_left;
        bit stall_done, r0, r1, mv, v0, v1;
        logic [15:0] mt;
        logic [1:0] exp_w2[5];

        // Reset values while asserted.
        #1 aresetn = 1'b0;
        #2;
        check("rst_async_mvalid", 512'(m_axis_tvalid), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_mvalid", 512'(m_axis_tvalid), 512'(0));
        check("rst_mlast", 512'(m_axis_tlast), 512'(0));
        check("rst_mdata", m_axis_tdata, 512'(0));
        check("rst_mkeep", 512'(m_axis_tkeep), 512'(0));
        check("rst_muser", 512'(m_axis_tuser), 512'(0));
        check("rst_s0rdy", 512'(s0_axis_tready), 512'(0));
        check("rst_s1rdy", 512'(s1_axis_tready), 512'(0));
        check("rst_cnt0", 512'(pkt_cnt0), 512'(0));
        check("rst_cnt1", 512'(pkt_cnt1), 512'(0));
        check("rst_state", 512'(grant_state), 512'(0));

        // Single 2-beat s0 packet, then simultaneous 3-beat packets on s0 and s1.
        vecs.push_back(mk(1, 1,0,16'hA1, 0,0,16'h0,  1, 0,0, 0,0,16'h0,  2'd1, 0,0));
        vecs.push_back(mk(0, 1,0,16'hA1, 0,0,16'h0,  1, 1,0, 1,0,16'hA1, 2'd1, 0,0));
        vecs.push_back(mk(0, 1,1,16'hA2, 0,0,16'h0,  1, 1,0, 1,1,16'hA2, 2'd0, 1,0));
        vecs.push_back(mk(0, 0,0,16'h0,  0,0,16'h0,  1, 0,0, 0,0,16'h0,  2'd0, 1,0));
        vecs.push_back(mk(1, 1,0,16'hB1, 1,0,16'hC1, 1, 0,0, 0,0,16'h0,  2'd1, 0,0));
        vecs.push_back(mk(0, 1,0,16'hB1, 1,0,16'hC1, 1, 1,0, 1,0,16'hB1, 2'd1, 0,0));
        vecs.push_back(mk(0, 1,0,16'hB2, 1,0,16'hC1, 1, 1,0, 1,0,16'hB2, 2'd1, 0,0));
        vecs.push_back(mk(0, 1,1,16'hB3, 1,0,16'hC1, 1, 1,0, 1,1,16'hB3, 2'd0, 1,0));
        vecs.push_back(mk(0, 0,0,16'h0,  1,0,16'hC1, 1, 0,0, 0,0,16'h0,  2'd2, 1,0));
        vecs.push_back(mk(0, 0,0,16'h0,  1,0,16'hC1, 1, 0,1, 1,0,16'hC1, 2'd2, 1,0));
        vecs.push_back(mk(0, 0,0,16'h0,  1,0,16'hC2, 1, 0,1, 1,0,16'hC2, 2'd2, 1,0));
        vecs.push_back(mk(0, 0,0,16'h0,  1,1,16'hC3, 1, 0,1, 1,1,16'hC3, 2'd0, 1,1));
        vecs.push_back(mk(0, 0,0,16'h0,  0,0,16'h0,  1, 0,0, 0,0,16'h0,  2'd0, 1,1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive_src(0, vecs[i].s0v, vecs[i].s0l, vecs[i].s0t);
            drive_src(1, vecs[i].s1v, vecs[i].s1l, vecs[i].s1t);
            m_axis_tready = vecs[i].mrdy;
            #1;
            check($sformatf("vec%0d_s0rdy", i), 512'(s0_axis_tready), 512'(vecs[i].e0r));
            check($sformatf("vec%0d_s1rdy", i), 512'(s1_axis_tready), 512'(vecs[i].e1r));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_mvalid", i), 512'(m_axis_tvalid), 512'(vecs[i].emv));
            check($sformatf("vec%0d_state", i), 512'(grant_state), 512'(vecs[i].est));
            check($sformatf("vec%0d_cnt0", i), 512'(pkt_cnt0), 512'(vecs[i].ec0));
            check($sformatf("vec%0d_cnt1", i), 512'(pkt_cnt1), 512'(vecs[i].ec1));
            if (vecs[i].emv) check_beat($sformatf("vec%0d", i), vecs[i].etag, vecs[i].eml);
        end

        // Both sources offer four 1-beat packets: output must alternate s0, s1, ...
        do_reset();
        sent0 = 0; sent1 = 0; rx = 0;
        for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
            v0 = (sent0 < 4);
            v1 = (sent1 < 4);
            drive_src(0, v0, 1'b1, 16'h30 + 16'(sent0));
            drive_src(1, v1, 1'b1, 16'h40 + 16'(sent1));
            #1;
            r0 = s0_axis_tready; r1 = s1_axis_tready; mv = m_axis_tvalid;
            if (mv) begin
                check_beat("alt_beat", (rx % 2 == 0) ? 16'h30 + 16'(rx / 2) : 16'h40 + 16'(rx / 2), 1'b1);
                rx++;
            end
            @(posedge clk);
            #1;
            if (v0 && r0) sent0++;
            if (v1 && r1) sent1++;
        end
        drive_src(0, 0, 0, 16'h0);
        drive_src(1, 0, 0, 16'h0);
        check("alt_beats_delivered", 512'(rx), 512'(8));
        check("alt_cnt0", 512'(pkt_cnt0), 512'(4));
        check("alt_cnt1", 512'(pkt_cnt1), 512'(4));

        // 4-beat s1 packet with a 5-cycle downstream stall after two beats delivered.
        do_reset();
        sent1 = 0; rx = 0; stall_left = 0; stall_done = 0;
        for (int cyc = 0; cyc < 60 && rx < 4; cyc++) begin
            if (rx == 2 && !stall_done) begin
                stall_left = 5;
                stall_done = 1;
            end
            v1 = (sent1 < 4);
            drive_src(1, v1, sent1 == 3, 16'h70 + 16'(sent1));
            m_axis_tready = (stall_left == 0);
            #1;
            r1 = s1_axis_tready; mv = m_axis_tvalid; mt = m_axis_tdata[15:0];
            if (stall_left > 0) begin
                check("stall_s1rdy", 512'(r1), 512'(0));
                check("stall_mvalid", 512'(mv), 512'(1));
                check_beat("stall_hold", 16'h70 + 16'(rx), 1'b0);
            end
            if (mv && m_axis_tready) begin
                check_beat("stall_beat", 16'h70 + 16'(rx), rx == 3);
                rx++;
            end
            @(posedge clk);
            #1;
            if (v1 && r1) sent1++;
            if (stall_left > 0) stall_left--;
        end
        drive_src(1, 0, 0, 16'h0);
        m_axis_tready = 1'b1;
        check("stall_beats_delivered", 512'(rx), 512'(4));
        check("stall_stall_seen", 512'(stall_done), 512'(1));
        check("stall_cnt1", 512'(pkt_cnt1), 512'(1));
        check("stall_cnt0", 512'(pkt_cnt0), 512'(0));

        // Reset pulsed while beat 2 of a 3-beat s0 packet is on the output.
        sent0 = 0;
        for (int cyc = 0; cyc < 20 && sent0 < 2; cyc++) begin
            drive_src(0, 1'b1, sent0 == 2, 16'h50 + 16'(sent0));
            #1;
            r0 = s0_axis_tready;
            @(posedge clk);
            #1;
            if (r0) sent0++;
        end
        check("midrst_beats_sent", 512'(sent0), 512'(2));
        check("midrst_pre_mvalid", 512'(m_axis_tvalid), 512'(1));
        #2 aresetn = 1'b0;
        #1;
        check("midrst_mvalid", 512'(m_axis_tvalid), 512'(0));
        check("midrst_state", 512'(grant_state), 512'(0));
        check("midrst_cnt0", 512'(pkt_cnt0), 512'(0));
        check("midrst_cnt1", 512'(pkt_cnt1), 512'(0));
        check("midrst_s0rdy", 512'(s0_axis_tready), 512'(0));
        drive_src(0, 0, 0, 16'h0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        run_pkt(1, 16'h58, 2);
        check("postrst_cnt1", 512'(pkt_cnt1), 512'(1));
        check("postrst_cnt0", 512'(pkt_cnt0), 512'(0));

        // Counter wrap on the 2-bit instance.
        do_reset();
        exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 5; k++) begin
            run_pkt(0, 16'h90 + 16'(k), 1);
            check($sformatf("wrap%0d_w2_cnt0", k), 512'(w2_cnt0), 512'(exp_w2[k]));
            check($sformatf("wrap%0d_cnt0", k), 512'(pkt_cnt0), 512'(k + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
